key_event_arbiter: RTL and testbench

- Glitch-filters KEYS raw key inputs and turns each debounced press into a one-shot event.
- Shares a single event output channel between all keys using round-robin arbitration and a valid/ready handshake.
- Sits between board buttons and control logic that consumes key events one at a time (menu FSM, UART reporter).

---
 rtl/key_evt_pkg.sv | 33 +++
 rtl/key_event_arbiter_key_filter.sv | 105 ++++++++++
 rtl/key_event_arbiter.sv | 160 ++++++++++++++++
 tb/tb_key_event_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
//   Shared types and helpers for the key event arbiter.
//   - key_state_t   : per-key glitch filter FSM states
//   - cnt_width_t   : type used to carry the filter counter width
//   - glitch_cycles : converts clock frequency and glitch time into cycles
//   - cnt_width     : number of counter bits needed to count up to a limit
//   Optional feature macro used by the files importing this package:
//   KEY_EVT_RELEASE_EN (release events in addition to press events).
// -----------------------------------------------------------------------------
package key_evt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CNT,
    HELD,
    REL_CNT
  } key_state_t;

  typedef int unsigned cnt_width_t;

  // Number of clock cycles a new level must stay stable before it is accepted.
  function automatic int unsigned glitch_cycles(input int unsigned freq_mhz,
                                                input int unsigned time_ns);
    return (time_ns * freq_mhz) / 1000;
  endfunction

  // Counter bits needed to hold the value 'cycles'.
  function automatic cnt_width_t cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_event_arbiter_key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
//   One raw key: 2-flop synchronizer followed by a glitch filter FSM. A level
//   change is accepted once the synchronized level has been stable for
//   GLITCH_CYCLES consecutive cycles.
//   Ports:
//     clk_i        in   clock
//     rst_ni       in   asynchronous active-low reset
//     key_i        in   raw asynchronous key level (1 = pressed)
//     press_done_o out  one-cycle pulse when a press is accepted
//     rel_done_o   out  one-cycle pulse when a release is accepted
//                       (present only when KEY_EVT_RELEASE_EN is defined)
// -----------------------------------------------------------------------------
module key_filter
  import key_evt_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_done_o
`ifdef KEY_EVT_RELEASE_EN
  ,
  output logic rel_done_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(GLITCH_CYCLES);
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(GLITCH_CYCLES);

  logic [1:0]       sync_q;
  logic             synced;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign synced  = sync_q[1];
  // One extra bit so the compare against LIMIT never wraps.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_done_o = 1'b0;
`ifdef KEY_EVT_RELEASE_EN
    rel_done_o   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (synced) begin
          state_d = PRESS_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_CNT: begin
        if (!synced) begin
          state_d = IDLE;
        end else if (cnt_inc >= LIMIT) begin
          state_d      = HELD;
          cnt_d        = '0;
          press_done_o = 1'b1;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      HELD: begin
        if (!synced) begin
          state_d = REL_CNT;
          cnt_d   = CNT_W'(1);
        end
      end
      REL_CNT: begin
        if (synced) begin
          state_d = HELD;
        end else if (cnt_inc >= LIMIT) begin
          state_d    = IDLE;
          cnt_d      = '0;
`ifdef KEY_EVT_RELEASE_EN
          rel_done_o = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_event_arbiter.sv
// -----------------------------------------------------------------------------
// key_event_arbiter
//   Glitch-filters KEYS raw keys and shares one valid/ready event channel
//   between them with round-robin arbitration. Each accepted press (and, with
//   KEY_EVT_RELEASE_EN defined, each accepted release) raises a pending bit;
//   the arbiter presents pending events one at a time.
//   Ports:
//     clk_i        in   clock
//     rst_ni       in   asynchronous active-low reset
//     key_i        in   raw key levels, 1 = pressed
//     evt_valid_o  out  event available
//     evt_id_o     out  index of the key owning the event
//     evt_rel_o    out  1 = release event, 0 = press event (0 without feature)
//     evt_ready_i  in   consumer accepts the event
//     ovf_o        out  sticky: an event was dropped
//   Optional feature macro: KEY_EVT_RELEASE_EN.
// -----------------------------------------------------------------------------
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int unsigned KEYS           = 4,
  parameter int unsigned CLK_FREQ_MHZ   = 100,
  parameter int unsigned GLITCH_TIME_NS = 100
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [KEYS-1:0]         key_i,
  output logic                    evt_valid_o,
  output logic [$clog2(KEYS)-1:0] evt_id_o,
  output logic                    evt_rel_o,
  input  logic                    evt_ready_i,
  output logic                    ovf_o
);

  localparam int unsigned GLITCH_CYCLES = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);

  // Request index: without release events it is the key index; with them it
  // is {key, rel} so a key's press sits just before its release.
`ifdef KEY_EVT_RELEASE_EN
  localparam int unsigned REQS = 2 * KEYS;
`else
  localparam int unsigned REQS = KEYS;
`endif
  localparam int unsigned REQ_W = $clog2(REQS);

  if (GLITCH_CYCLES < 1) begin : g_glitch_cfg_err
    $error("key_event_arbiter: GLITCH_CYCLES must be at least 1");
  end
  if (KEYS < 2 || KEYS > 16) begin : g_keys_cfg_err
    $error("key_event_arbiter: KEYS must be in 2..16");
  end

  logic [KEYS-1:0] press_done;
`ifdef KEY_EVT_RELEASE_EN
  logic [KEYS-1:0] rel_done;
`endif
  logic [REQS-1:0] req_set;

  for (genvar gi = 0; gi < KEYS; gi++) begin : g_key
    key_filter #(
      .GLITCH_CYCLES(GLITCH_CYCLES)
    ) u_filter (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .key_i       (key_i[gi]),
      .press_done_o(press_done[gi])
`ifdef KEY_EVT_RELEASE_EN
      ,
      .rel_done_o  (rel_done[gi])
`endif
    );
`ifdef KEY_EVT_RELEASE_EN
    assign req_set[2*gi]   = press_done[gi];
    assign req_set[2*gi+1] = rel_done[gi];
`endif
  end

`ifndef KEY_EVT_RELEASE_EN
  assign req_set = press_done;
`endif

  logic [REQS-1:0]  pending_q, pending_d;
  logic [REQ_W-1:0] ptr_q, ptr_d;
  logic [REQ_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             hs;
  logic [REQS-1:0]  hs_mask;
  logic [REQS-1:0]  cand;
  logic             found;
  logic [REQ_W-1:0] pick;
  logic [31:0]      idx;

  function automatic logic [REQ_W-1:0] wrap_inc(input logic [REQ_W-1:0] v);
    if (v == REQ_W'(REQS - 1)) return '0;
    return v + REQ_W'(1);
  endfunction

  always_comb begin
    hs      = valid_q & evt_ready_i;
    hs_mask = '0;
    if (hs) hs_mask[sel_q] = 1'b1;

    // Pending bits still owed to the consumer once this cycle's handshake
    // retires; a completion landing on one of these is a dropped event.
    cand      = pending_q & ~hs_mask;
    pending_d = cand | req_set;
    ovf_d     = ovf_q | (|(req_set & cand));
    ptr_d     = hs ? wrap_inc(sel_q) : ptr_q;

    // Round-robin search starting at the (possibly just advanced) pointer.
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      idx = 32'(ptr_d) + i;
      if (idx >= REQS) idx = idx - REQS;
      if (!found && cand[idx[REQ_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[REQ_W-1:0];
      end
    end

    // The presented event is frozen until it is handshaked.
    valid_d = valid_q;
    sel_d   = sel_q;
    if (!valid_q || hs) begin
      valid_d = found;
      if (found) sel_d = pick;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign ovf_o       = ovf_q;
`ifdef KEY_EVT_RELEASE_EN
  assign evt_id_o    = sel_q[REQ_W-1:1];
  assign evt_rel_o   = sel_q[0];
`else
  assign evt_id_o    = sel_q;
  assign evt_rel_o   = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_key_event_arbiter
//   Directed, table-driven bench for key_event_arbiter at default parameters
//   (KEYS=4, GLITCH_CYCLES=10). Each table row drives key/ready, advances a
//   number of clock cycles and compares the outputs against hand-computed
//   values. Reset behaviour is exercised by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_key_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key = 4'b0000;
  logic       ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_rel;
  logic       ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_event_arbiter #(
    .KEYS          (4),
    .CLK_FREQ_MHZ  (100),
    .GLITCH_TIME_NS(100)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .key_i      (key),
    .evt_valid_o(evt_valid),
    .evt_id_o   (evt_id),
    .evt_rel_o  (evt_rel),
    .evt_ready_i(ready),
    .ovf_o      (ovf)
  );

  typedef struct {
    string      name;
    logic [3:0] key;
    logic       ready;
    int         cycles;
    logic       quiet;   // evt_valid must stay low on every cycle of the row
    logic       v;
    logic [1:0] id;
    logic       rel;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic [3:0] k, input logic r,
                     input int cyc, input logic q, input logic v,
                     input logic [1:0] id, input logic rel, input logic o);
    vec_t e;
    e.name = name; e.key = k; e.ready = r; e.cycles = cyc; e.quiet = q;
    e.v = v; e.id = id; e.rel = rel; e.ovf = o;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic run_vec(input int n, input vec_t e);
    logic seen;
    key   = e.key;
    ready = e.ready;
    seen  = 1'b0;
    for (int c = 0; c < e.cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | evt_valid;
    end
    if (e.quiet) check({e.name, ".quiet"}, int'(seen), 0);
    check({e.name, ".valid"}, int'(evt_valid), int'(e.v));
    if (e.v) begin
      check({e.name, ".id"}, int'(evt_id), int'(e.id));
      check({e.name, ".rel"}, int'(evt_rel), int'(e.rel));
    end
    check({e.name, ".ovf"}, int'(ovf), int'(e.ovf));
    $display("vec %0d %s: key=%b ready=%b cycles=%0d -> valid=%b id=%0d rel=%b ovf=%b",
             n, e.name, e.key, e.ready, e.cycles, evt_valid, evt_id, evt_rel, ovf);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.valid", int'(evt_valid), 0);
    check("reset.id", int'(evt_id), 0);
    check("reset.rel", int'(evt_rel), 0);
    check("reset.ovf", int'(ovf), 0);
    $display("reset: valid=%b id=%0d rel=%b ovf=%b", evt_valid, evt_id, evt_rel, ovf);
    rst_n = 1'b1;
    ready = 1'b1;

`ifdef KEY_EVT_RELEASE_EN
    // Press then release of key 1: press event, later a release event.
    //  name              key      rdy cyc q  v  id rel ovf
    add("rel_press_wait", 4'b0010, 1, 12, 1, 0, 0, 0, 0);
    add("rel_press_evt",  4'b0010, 1,  1, 0, 1, 1, 0, 0);
    add("rel_press_once", 4'b0010, 1,  1, 0, 0, 0, 0, 0);
    add("rel_hold",       4'b0010, 1,  6, 1, 0, 0, 0, 0);
    add("rel_fall_wait",  4'b0000, 1, 12, 1, 0, 0, 0, 0);
    add("rel_evt",        4'b0000, 1,  1, 0, 1, 1, 1, 0);
    add("rel_once",       4'b0000, 1,  1, 0, 0, 0, 0, 0);
    add("rel_idle",       4'b0000, 1, 20, 1, 0, 0, 0, 0);
    run_table();
`else
    // Simultaneous keys 1 and 3 from pointer 0, twice (pointer wraps to 0).
    //  name             key      rdy cyc q  v  id rel ovf
    add("pair_wait",     4'b1010, 1, 12, 1, 0, 0, 0, 0);
    add("pair_first",    4'b1010, 1,  1, 0, 1, 1, 0, 0);
    add("pair_second",   4'b1010, 1,  1, 0, 1, 3, 0, 0);
    add("pair_idle",     4'b1010, 1,  1, 0, 0, 0, 0, 0);
    add("pair_held",     4'b1010, 1, 20, 1, 0, 0, 0, 0);
    add("pair_release",  4'b0000, 1, 20, 1, 0, 0, 0, 0);
    add("pair2_wait",    4'b1010, 1, 12, 1, 0, 0, 0, 0);
    add("pair2_first",   4'b1010, 1,  1, 0, 1, 1, 0, 0);
    add("pair2_second",  4'b1010, 1,  1, 0, 1, 3, 0, 0);
    add("pair2_idle",    4'b1010, 1,  1, 0, 0, 0, 0, 0);
    add("pair2_release", 4'b0000, 1, 20, 1, 0, 0, 0, 0);
    // Key 2 alone: event exactly on cycle 13, single-cycle, none while held.
    add("k2_wait",       4'b0100, 1, 12, 1, 0, 0, 0, 0);
    add("k2_evt",        4'b0100, 1,  1, 0, 1, 2, 0, 0);
    add("k2_single",     4'b0100, 1,  1, 0, 0, 0, 0, 0);
    add("k2_held",       4'b0100, 1, 20, 1, 0, 0, 0, 0);
    add("k2_release",    4'b0000, 1, 20, 1, 0, 0, 0, 0);
    // Pointer now 3: keys 2 and 3 -> 3 first, then 2 after wrapping.
    add("rr_wait",       4'b1100, 1, 12, 1, 0, 0, 0, 0);
    add("rr_first",      4'b1100, 1,  1, 0, 1, 3, 0, 0);
    add("rr_second",     4'b1100, 1,  1, 0, 1, 2, 0, 0);
    add("rr_idle",       4'b1100, 1,  1, 0, 0, 0, 0, 0);
    add("rr_release",    4'b0000, 1, 20, 1, 0, 0, 0, 0);
    // Short pulses on key 0 never produce an event.
    for (int r = 0; r < 5; r++) begin
      add($sformatf("glitch_hi%0d", r), 4'b0001, 1, 8, 1, 0, 0, 0, 0);
      add($sformatf("glitch_lo%0d", r), 4'b0000, 1, 8, 1, 0, 0, 0, 0);
    end
    // Stalled consumer: second press of key 0 is dropped, event held stable.
    add("ovf_first",     4'b0001, 0, 13, 0, 1, 0, 0, 0);
    add("ovf_release",   4'b0000, 0, 12, 0, 1, 0, 0, 0);
    add("ovf_repress",   4'b0001, 0, 14, 0, 1, 0, 0, 1);
    add("ovf_drain",     4'b0001, 1,  1, 0, 0, 0, 0, 1);
    add("ovf_after",     4'b0001, 1,  5, 1, 0, 0, 0, 1);
    add("ovf_release2",  4'b0000, 1, 20, 1, 0, 0, 0, 1);
    // Pointer now 1: key 2 event presented and stalled before the reset.
    add("rst_press",     4'b0100, 0, 13, 0, 1, 2, 0, 1);
    run_table();

    // Asynchronous reset while an event is presented.
    rst_n = 1'b0;
    key   = 4'b0000;
    #1;
    check("async_rst.valid", int'(evt_valid), 0);
    check("async_rst.id", int'(evt_id), 0);
    check("async_rst.rel", int'(evt_rel), 0);
    check("async_rst.ovf", int'(ovf), 0);
    $display("async reset: valid=%b id=%0d rel=%b ovf=%b", evt_valid, evt_id, evt_rel, ovf);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;

    add("rst_quiet",     4'b0000, 1, 30, 1, 0, 0, 0, 0);
    add("rst_rep_wait",  4'b0100, 1, 12, 1, 0, 0, 0, 0);
    add("rst_repress",   4'b0100, 1,  1, 0, 1, 2, 0, 0);
    add("rst_single",    4'b0100, 1,  1, 0, 0, 0, 0, 0);
    add("rst_release",   4'b0000, 1, 20, 1, 0, 0, 0, 0);
    run_table();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
